switch_mcu_exec_ctrl: RTL and testbench

- Execution sequencer and register-file port arbiter for the single-issue switch MCU ALU units (addi, srli, slli, add, …).
- Accepts one decoded instruction at a time and latches its fields.
- Drives the shared cycle counter and a one-hot enable to the selected unit.
- Muxes that unit's register-file read/write requests onto the single shared register-file port pair; signals completion to the decoder.

---
 rtl/switch_mcu_exec_ctrl_pkg.sv | 36 +++
 rtl/switch_mcu_exec_ctrl_if.sv | 55 +++++
 rtl/switch_mcu_exec_ctrl_rf_port_mux.sv | 36 +++
 rtl/switch_mcu_exec_ctrl.sv | 131 +++++++++++++
 tb/tb_switch_mcu_exec_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_mcu_exec_ctrl_pkg.sv
// Shared definitions for the switch MCU execution controller: FSM state
// encodings, counter/operand widths, ALU unit indices and the muxed
// register-file request bundle.
package switch_mcu_pkg;

  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;
  localparam int IMM_W    = 12;
  localparam int CNT_W    = 4;
  localparam int LAST_CNT = 4;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_EXEC = 2'd1,
    STATE_WB   = 2'd2
  } state_t;

  localparam int UNIT_ADDI = 0;
  localparam int UNIT_SRLI = 1;
  localparam int UNIT_SLLI = 2;
  localparam int UNIT_ADD  = 3;
  localparam int UNIT_SUB  = 4;
  localparam int UNIT_AND  = 5;
  localparam int UNIT_OR   = 6;
  localparam int UNIT_XOR  = 7;

  // One register-file request as seen on the shared port pair.
  typedef struct packed {
    logic              ren;
    logic [REG_AW-1:0] raddr;
    logic              wen;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
  } rf_req_t;

endpackage

// File: rtl/switch_mcu_exec_ctrl_if.sv
// Decoder/ALU-unit side bus of the execution controller. The master side
// (decoder and units) drives the in_* signals, the controller (slave)
// drives the out_* signals. Per-unit request fields are packed arrays, so
// unit k occupies bits [W*k+W-1:W*k] of the flattened vector.
interface switch_mcu_exec_ctrl_if #(
  parameter int NUM_UNITS = 8,
  parameter int UNIT_W    = 3
);
  import switch_mcu_pkg::*;

  logic                                in_inst_valid;
  logic                                out_inst_ready;
  logic [UNIT_W-1:0]                   in_unit_sel;
  logic [REG_AW-1:0]                   in_rs1;
  logic [REG_AW-1:0]                   in_rd;
  logic [IMM_W-1:0]                    in_imm_type_i;

  logic [NUM_UNITS-1:0]                out_unit_en;
  logic [CNT_W-1:0]                    out_cycle_cnt;
  logic [REG_AW-1:0]                   out_rs1;
  logic [REG_AW-1:0]                   out_rd;
  logic [IMM_W-1:0]                    out_imm_type_i;

  logic [NUM_UNITS-1:0]                in_unit_ren_1;
  logic [NUM_UNITS-1:0][REG_AW-1:0]    in_unit_raddr_1;
  logic [NUM_UNITS-1:0]                in_unit_wen;
  logic [NUM_UNITS-1:0][REG_AW-1:0]    in_unit_waddr;
  logic [NUM_UNITS-1:0][XLEN-1:0]      in_unit_wdata;

  logic                                out_ren_1;
  logic [REG_AW-1:0]                   out_raddr_1;
  logic                                out_wen;
  logic [REG_AW-1:0]                   out_waddr;
  logic [XLEN-1:0]                     out_wdata;
  logic                                out_done;
  logic                                out_err;
  logic                                out_busy;

  modport master (
    output in_inst_valid, in_unit_sel, in_rs1, in_rd, in_imm_type_i,
           in_unit_ren_1, in_unit_raddr_1, in_unit_wen, in_unit_waddr, in_unit_wdata,
    input  out_inst_ready, out_unit_en, out_cycle_cnt, out_rs1, out_rd, out_imm_type_i,
           out_ren_1, out_raddr_1, out_wen, out_waddr, out_wdata,
           out_done, out_err, out_busy
  );

  modport slave (
    input  in_inst_valid, in_unit_sel, in_rs1, in_rd, in_imm_type_i,
           in_unit_ren_1, in_unit_raddr_1, in_unit_wen, in_unit_waddr, in_unit_wdata,
    output out_inst_ready, out_unit_en, out_cycle_cnt, out_rs1, out_rd, out_imm_type_i,
           out_ren_1, out_raddr_1, out_wen, out_waddr, out_wdata,
           out_done, out_err, out_busy
  );

endinterface

// File: rtl/switch_mcu_exec_ctrl_rf_port_mux.sv
// Combinational selector that forwards the active unit's register-file
// request onto the single shared port pair. With gate low the shared port
// is held at zero so idle units cannot touch the register file.
module switch_mcu_rf_port_mux
  import switch_mcu_pkg::*;
#(
  parameter int NUM_UNITS = 8,
  parameter int UNIT_W    = 3
) (
  input  logic [UNIT_W-1:0]                sel,
  input  logic                             gate,
  input  logic [NUM_UNITS-1:0]             ren,
  input  logic [NUM_UNITS-1:0][REG_AW-1:0] raddr,
  input  logic [NUM_UNITS-1:0]             wen,
  input  logic [NUM_UNITS-1:0][REG_AW-1:0] waddr,
  input  logic [NUM_UNITS-1:0][XLEN-1:0]   wdata,
  output rf_req_t                          req
);

  // Pick exactly the selected slice; every other unit is ignored.
  always_comb begin
    req = '0;
    if (gate) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (sel == UNIT_W'(k)) begin
          req.ren   = ren[k];
          req.raddr = raddr[k];
          req.wen   = wen[k];
          req.waddr = waddr[k];
          req.wdata = wdata[k];
        end
      end
    end
  end

endmodule

// File: rtl/switch_mcu_exec_ctrl.sv
// Execution sequencer for the single-issue switch MCU ALU units. Accepts a
// decoded instruction, enables one unit for LAST_CNT execute cycles, then
// spends one write-back cycle with the unit's write routed to the shared
// register-file port. A new instruction may be accepted in write-back so
// back-to-back instructions cost LAST_CNT+1 cycles each.
module switch_mcu_exec_ctrl
  import switch_mcu_pkg::*;
#(
  parameter int NUM_UNITS = 8,
  parameter int UNIT_W    = 3,
  parameter int LAST_CNT  = switch_mcu_pkg::LAST_CNT
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  switch_mcu_exec_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_CNT);
  localparam logic [CNT_W-1:0] CNT_WB   = CNT_W'(LAST_CNT + 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_UNITS-1:0] unit_en;
  logic [NUM_UNITS-1:0] sel_hot;
  logic [UNIT_W-1:0]    sel_q;
  logic [REG_AW-1:0]    rs1_q;
  logic [REG_AW-1:0]    rd_q;
  logic [IMM_W-1:0]     imm_q;
  logic                 done_q;
  logic                 err_q;
  logic                 ready;
  logic                 take;
  logic                 sel_ok;
  rf_req_t              rf_req;

  assign ready  = (state == STATE_IDLE) || (state == STATE_WB);
  assign take   = bus.in_inst_valid && ready;
  assign sel_ok = int'(bus.in_unit_sel) < NUM_UNITS;

  // One-hot decode of the incoming unit index (only used when sel_ok).
  always_comb begin
    sel_hot = '0;
    for (int k = 0; k < NUM_UNITS; k++)
      sel_hot[k] = (bus.in_unit_sel == UNIT_W'(k));
  end

  // Sequencer: IDLE -> EXEC (cnt 1..LAST) -> WB (cnt LAST+1) -> IDLE/EXEC.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state   <= STATE_IDLE;
      cnt     <= '0;
      unit_en <= '0;
      sel_q   <= '0;
      rs1_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (take && sel_ok) begin
        state   <= STATE_EXEC;
        cnt     <= CNT_W'(1);
        unit_en <= sel_hot;
        sel_q   <= bus.in_unit_sel;
        rs1_q   <= bus.in_rs1;
        rd_q    <= bus.in_rd;
        imm_q   <= bus.in_imm_type_i;
      end else if (take) begin
        // Illegal unit: consume and drop, flag it for one cycle.
        state   <= STATE_IDLE;
        cnt     <= '0;
        unit_en <= '0;
        err_q   <= 1'b1;
      end else begin
        case (state)
          STATE_EXEC: begin
            if (cnt == CNT_LAST) begin
              state   <= STATE_WB;
              cnt     <= CNT_WB;
              unit_en <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          STATE_WB: begin
            state <= STATE_IDLE;
            cnt   <= '0;
          end
          default: begin
            state   <= STATE_IDLE;
            cnt     <= '0;
            unit_en <= '0;
          end
        endcase
      end
    end
  end

  switch_mcu_rf_port_mux #(
    .NUM_UNITS (NUM_UNITS),
    .UNIT_W    (UNIT_W)
  ) u_rf_port_mux (
    .sel   (sel_q),
    .gate  (state != STATE_IDLE),
    .ren   (bus.in_unit_ren_1),
    .raddr (bus.in_unit_raddr_1),
    .wen   (bus.in_unit_wen),
    .waddr (bus.in_unit_waddr),
    .wdata (bus.in_unit_wdata),
    .req   (rf_req)
  );

  assign bus.out_inst_ready = ready;
  assign bus.out_unit_en    = unit_en;
  assign bus.out_cycle_cnt  = cnt;
  assign bus.out_rs1        = rs1_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_imm_type_i = imm_q;
  assign bus.out_ren_1      = rf_req.ren;
  assign bus.out_raddr_1    = rf_req.raddr;
  assign bus.out_wen        = rf_req.wen;
  assign bus.out_waddr      = rf_req.waddr;
  assign bus.out_wdata      = rf_req.wdata;
  assign bus.out_done       = done_q;
  assign bus.out_err        = err_q;
  assign bus.out_busy       = (state != STATE_IDLE);

endmodule

// File: tb/tb_switch_mcu_exec_ctrl.sv
// Bench for switch_mcu_exec_ctrl: simple behavioural ALU units and a
// register file around the DUT, an instruction-position model compared
// against every output each cycle, and directed scenarios with literal
// expectations.
module tb_switch_mcu_exec_ctrl;
  import switch_mcu_pkg::*;

  localparam int N  = 8;
  localparam int UW = 4;
  localparam int L  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_on = 1'b0;
  logic rogue = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  switch_mcu_exec_ctrl_if #(.NUM_UNITS(N), .UNIT_W(UW)) bus ();

  switch_mcu_exec_ctrl #(.NUM_UNITS(N), .UNIT_W(UW), .LAST_CNT(L)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register file and ALU unit models ----------------
  logic [XLEN-1:0] regs [32];
  logic            armed [N];
  logic [XLEN-1:0] opnd  [N];

  function automatic logic [XLEN-1:0] unit_op(input int k, input logic [XLEN-1:0] a,
                                              input logic [IMM_W-1:0] imm);
    case (k)
      UNIT_ADDI: return a + {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
      UNIT_SRLI: return a >> imm[4:0];
      UNIT_SLLI: return a << imm[4:0];
      default:   return a ^ XLEN'(k);
    endcase
  endfunction

  // Register file: reset image, then absorb writes from the shared port.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= XLEN'(i) * 32'h0101_0101;
      regs[3] <= 32'h0000_F0F0;
    end else if (bus.out_wen) begin
      regs[bus.out_waddr] <= bus.out_wdata;
    end
  end

  // Units remember they were enabled and fetch their operand on cycle 1.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (bus.out_unit_en[k]) armed[k] <= 1'b1;
      else if (bus.out_cycle_cnt == 4'(L + 1) || bus.out_cycle_cnt == 4'd0) armed[k] <= 1'b0;
      if (bus.out_unit_en[k] && bus.out_cycle_cnt == 4'd1) opnd[k] <= regs[bus.out_rs1];
    end
  end

  // Unit request outputs; unit 3 can be forced to misbehave.
  always_comb begin
    bus.in_unit_ren_1   = '0;
    bus.in_unit_raddr_1 = '0;
    bus.in_unit_wen     = '0;
    bus.in_unit_waddr   = '0;
    bus.in_unit_wdata   = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.out_unit_en[k] && bus.out_cycle_cnt == 4'd1) begin
        bus.in_unit_ren_1[k]   = 1'b1;
        bus.in_unit_raddr_1[k] = bus.out_rs1;
      end
      if (armed[k] === 1'b1 && bus.out_cycle_cnt == 4'(L + 1)) begin
        bus.in_unit_wen[k]   = 1'b1;
        bus.in_unit_waddr[k] = bus.out_rd;
        bus.in_unit_wdata[k] = unit_op(k, opnd[k], bus.out_imm_type_i);
      end
      if (rogue && k == 3) begin
        bus.in_unit_ren_1[k]   = 1'b1;
        bus.in_unit_raddr_1[k] = 5'd31;
        bus.in_unit_wen[k]     = 1'b1;
        bus.in_unit_waddr[k]   = 5'd31;
        bus.in_unit_wdata[k]   = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- reference model ----------------
  // m_pos is the position inside the current instruction: 0 idle,
  // 1..L executing, L+1 writing back.
  int              m_pos;
  int              m_unit;
  logic            m_err;
  logic [4:0]      m_rs1, m_rd;
  logic [11:0]     m_imm;

  always @(posedge clk) begin
    if (rst) begin
      m_pos <= 0; m_unit <= 0; m_err <= 1'b0;
      m_rs1 <= '0; m_rd <= '0; m_imm <= '0;
    end else begin
      m_err <= 1'b0;
      if (bus.in_inst_valid && (m_pos == 0 || m_pos == L + 1)) begin
        if (int'(bus.in_unit_sel) < N) begin
          m_pos <= 1; m_unit <= int'(bus.in_unit_sel);
          m_rs1 <= bus.in_rs1; m_rd <= bus.in_rd; m_imm <= bus.in_imm_type_i;
        end else begin
          m_pos <= 0; m_err <= 1'b1;
        end
      end else if (m_pos >= 1 && m_pos <= L) m_pos <= m_pos + 1;
      else m_pos <= 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic act_b;
      act_b = (m_pos != 0);
      chk("ready", 64'(bus.out_inst_ready), 64'(m_pos == 0 || m_pos == L + 1));
      chk("cnt",   64'(bus.out_cycle_cnt), 64'(m_pos));
      chk("en",    64'(bus.out_unit_en), (m_pos >= 1 && m_pos <= L) ? (64'd1 << m_unit) : 64'd0);
      chk("done",  64'(bus.out_done), 64'(m_pos == L + 1));
      chk("err",   64'(bus.out_err), 64'(m_err));
      chk("busy",  64'(bus.out_busy), 64'(act_b));
      chk("rs1",   64'(bus.out_rs1), 64'(m_rs1));
      chk("rd",    64'(bus.out_rd), 64'(m_rd));
      chk("imm",   64'(bus.out_imm_type_i), 64'(m_imm));
      chk("ren",   64'(bus.out_ren_1),   act_b ? 64'(bus.in_unit_ren_1[m_unit])   : 64'd0);
      chk("raddr", 64'(bus.out_raddr_1), act_b ? 64'(bus.in_unit_raddr_1[m_unit]) : 64'd0);
      chk("wen",   64'(bus.out_wen),     act_b ? 64'(bus.in_unit_wen[m_unit])     : 64'd0);
      chk("waddr", 64'(bus.out_waddr),   act_b ? 64'(bus.in_unit_waddr[m_unit])   : 64'd0);
      chk("wdata", 64'(bus.out_wdata),   act_b ? 64'(bus.in_unit_wdata[m_unit])   : 64'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [UW-1:0] sel, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic [11:0] imm);
    bus.in_inst_valid = 1'b1;
    bus.in_unit_sel   = sel;
    bus.in_rs1        = rs1;
    bus.in_rd         = rd;
    bus.in_imm_type_i = imm;
  endtask

  initial begin
    bus.in_inst_valid = 1'b0;
    bus.in_unit_sel   = '0;
    bus.in_rs1        = '0;
    bus.in_rd         = '0;
    bus.in_imm_type_i = '0;
    cyc();
    chk_on = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_cnt", 64'(bus.out_cycle_cnt), 64'd0);
    chk("rst_en",  64'(bus.out_unit_en), 64'd0);
    chk("rst_rdy", 64'(bus.out_inst_ready), 64'd1);

    // Idle with valid low: nothing moves.
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_rdy",  64'(bus.out_inst_ready), 64'd1);
      chk("idle_cnt",  64'(bus.out_cycle_cnt), 64'd0);
      chk("idle_wen",  64'(bus.out_wen), 64'd0);
      chk("idle_done", 64'(bus.out_done), 64'd0);
    end

    // Single srli: x7 = x3 >> 4.
    issue(4'd1, 5'd3, 5'd7, 12'd4);
    cyc();
    bus.in_inst_valid = 1'b0;
    chk("s_cnt1",  64'(bus.out_cycle_cnt), 64'd1);
    chk("s_en",    64'(bus.out_unit_en), 64'h02);
    chk("s_raddr", 64'(bus.out_raddr_1), 64'd3);
    for (int c = 2; c <= 4; c++) begin
      cyc();
      chk("s_cnt", 64'(bus.out_cycle_cnt), 64'(c));
      chk("s_en",  64'(bus.out_unit_en), 64'h02);
    end
    cyc();
    chk("s_wbcnt", 64'(bus.out_cycle_cnt), 64'd5);
    chk("s_wben",  64'(bus.out_unit_en), 64'd0);
    chk("s_done",  64'(bus.out_done), 64'd1);
    chk("s_wen",   64'(bus.out_wen), 64'd1);
    chk("s_waddr", 64'(bus.out_waddr), 64'd7);
    chk("s_wdata", 64'(bus.out_wdata), 64'h0F0F);
    cyc();
    chk("s_idle",  64'(bus.out_cycle_cnt), 64'd0);
    chk("s_reg7",  64'(regs[7]), 64'h0F0F);

    // Back-to-back: srli then slli, second accepted in WB.
    issue(4'd1, 5'd3, 5'd9, 12'd2);
    cyc();
    issue(4'd2, 5'd3, 5'd10, 12'd1);
    cyc();
    chk("b_rdy", 64'(bus.out_inst_ready), 64'd0);
    cyc();
    cyc();
    cyc();
    chk("b_wbcnt", 64'(bus.out_cycle_cnt), 64'd5);
    chk("b_waddr", 64'(bus.out_waddr), 64'd9);
    chk("b_wdata", 64'(bus.out_wdata), 64'h3C3C);
    cyc();
    bus.in_inst_valid = 1'b0;
    chk("b_cnt1", 64'(bus.out_cycle_cnt), 64'd1);
    chk("b_en",   64'(bus.out_unit_en), 64'h04);
    for (int c = 0; c < 4; c++) cyc();
    chk("b2_waddr", 64'(bus.out_waddr), 64'd10);
    chk("b2_wdata", 64'(bus.out_wdata), 64'h1E1E0);
    cyc();
    chk("b2_idle", 64'(bus.out_cycle_cnt), 64'd0);

    // Illegal unit index in IDLE.
    issue(4'd8, 5'd1, 5'd2, 12'd0);
    cyc();
    bus.in_inst_valid = 1'b0;
    chk("i_err",  64'(bus.out_err), 64'd1);
    chk("i_en",   64'(bus.out_unit_en), 64'd0);
    chk("i_busy", 64'(bus.out_busy), 64'd0);
    cyc();
    chk("i_err0", 64'(bus.out_err), 64'd0);
    chk("i_done", 64'(bus.out_done), 64'd0);

    // Isolation: unit 3 drives garbage while unit 0 runs addi.
    rogue = 1'b1;
    cyc();
    chk("o_ren",   64'(bus.out_ren_1), 64'd0);
    chk("o_wen",   64'(bus.out_wen), 64'd0);
    chk("o_waddr", 64'(bus.out_waddr), 64'd0);
    chk("o_wdata", 64'(bus.out_wdata), 64'd0);
    issue(4'd0, 5'd3, 5'd5, 12'hFFF);
    cyc();
    bus.in_inst_valid = 1'b0;
    for (int c = 1; c <= L + 1; c++) begin
      chk("o_no31", 64'(bus.out_waddr == 5'd31), 64'd0);
      if (c <= L) cyc();
    end
    chk("o_wdata", 64'(bus.out_wdata), 64'hF0EF);
    // Illegal index presented in WB: dropped, back to IDLE.
    issue(4'd9, 5'd0, 5'd0, 12'd0);
    cyc();
    bus.in_inst_valid = 1'b0;
    chk("w_err", 64'(bus.out_err), 64'd1);
    chk("w_cnt", 64'(bus.out_cycle_cnt), 64'd0);
    chk("w_rdy", 64'(bus.out_inst_ready), 64'd1);
    rogue = 1'b0;

    // Reset mid-instruction.
    issue(4'd2, 5'd3, 5'd11, 12'd3);
    cyc();
    bus.in_inst_valid = 1'b0;
    cyc();
    chk("r_cnt2", 64'(bus.out_cycle_cnt), 64'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("r_cnt", 64'(bus.out_cycle_cnt), 64'd0);
    chk("r_en",  64'(bus.out_unit_en), 64'd0);
    chk("r_rdy", 64'(bus.out_inst_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("r_wen",  64'(bus.out_wen), 64'd0);
      chk("r_done", 64'(bus.out_done), 64'd0);
    end

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
